tff_seq_ctrl: RTL
=================

# tff_seq_ctrl

Sequencing controller for a WIDTH-bit bank of synchronous T flip-flops. It accepts count-up, count-down, load and no-op commands over a valid/ready handshake. For each command it generates the per-bit toggle vector that drives the bank one step per clock, then signals completion. It sits between a command source and the T-FF register bank, which it instantiates internally.

## Interface
- WIDTH, 4, number of T flip-flops in the bank (≥2)
- LEN_W, 8, width of the step-count field
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk; priority over all other inputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 NOP, 01 UP, 10 DOWN, 11 LOAD
- cmd_len  in  LEN_W  step count for UP/DOWN; ignored for NOP/LOAD
- cmd_data  in  WIDTH  target value for LOAD; ignored otherwise
- q  out  WIDTH  T-FF bank state
- busy  out  1  command in progress (state RUN)
- done  out  1  one-cycle completion pulse
- wrap  out  1  one-cycle pulse: q wrapped (all-ones→0 on UP, 0→all-ones on DOWN)

## Operation
- FSM states: IDLE, RUN, DONE.
- cmd_ready = (state==IDLE) && !reset. A command is accepted on an edge where cmd_valid && cmd_ready.
- On accept, the controller latches op, len and data.
  - UP/DOWN with len>0 → RUN, rem=len.
  - UP/DOWN with len=0 → DONE, no toggle.
  - LOAD → RUN, rem=1.
  - NOP → DONE.
- Toggle vector t, nonzero only in RUN:
  - UP: t[0]=1, t[i]=&q[i-1:0].
  - DOWN: t[0]=1, t[i]=&(~q[i-1:0]).
  - LOAD: t=q^data.
- In RUN, each edge toggles the bank and decrements rem. The edge where rem==1 moves the FSM to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- Arithmetic is modulo 2^WIDTH. UP from all-ones gives 0; DOWN from 0 gives all-ones. Each such step raises wrap in the cycle q shows the wrapped value. Multiple wraps in one command produce multiple pulses.
- cmd_valid, cmd_op, cmd_len and cmd_data are ignored while cmd_ready=0. There is no queuing; the source must hold its command.
- Reset at any point, including mid-RUN: q=0, state IDLE, rem=0, busy=0, done=0, wrap=0. No done pulse is emitted for an aborted command.

## Timing
- Reset values: q=0, busy=0, done=0, wrap=0. cmd_ready=0 while reset is high and 1 in the first cycle after reset deasserts.
- Command accepted at edge E0, UP/DOWN with len=N:
  - q updates at edges E1..EN.
  - busy is high in the cycles after E0..E(N-1).
  - done is high in the cycle after EN.
  - cmd_ready returns in the cycle after E(N+1).
- LOAD: q=data after E1; done follows E1.
- NOP, or len=0: done in the cycle after E0; q unchanged.
- Minimum command-to-command spacing is len+2 cycles for UP/DOWN with len>0, 3 for LOAD, and 2 for NOP or len=0.
- wrap is registered and coincident with the wrapped q value.
- done and wrap may be high in the same cycle only when the final step wraps.

## Structure
- Package tff_pkg holds:
  - op encodings OP_NOP, OP_UP, OP_DOWN, OP_LOAD
  - state enum IDLE/RUN/DONE
- Sub-module tff_reg holds the WIDTH T flip-flops:
  - ports clk, reset, t[WIDTH-1:0], q[WIDTH-1:0]
  - synchronous active-high reset to 0
  - q[i] toggles when t[i]=1
- tff_seq_ctrl holds the FSM, rem counter, t-vector logic and wrap/done registers.

## Test plan
All scenarios use WIDTH=4.
- Reset 2 cycles, then UP len=5 → q 1,2,3,4,5 on successive edges; done pulses once; cmd_ready high one cycle later.
- From q=0, DOWN len=1 → q=0xF; wrap=1 and done=1 in the same cycle.
- From q=0x5, LOAD data=0xA → t=0xF for one cycle; q=0xA; done next cycle.
- UP len=0, then NOP → each gives done one cycle after accept with no busy; q unchanged.
- UP len=10, reset asserted after 3 steps (q=3) → next cycle q=0, busy=0, cmd_ready=0 while reset is high; no done ever.
- Hold cmd_valid with DOWN len=2 while UP len=3 is busy → second command not accepted until cmd_ready=1, then q steps 3→2→1.

Source files
------------

// File: rtl/tff_pkg.sv
// ============================================================================
// Module   : tff_pkg
// Brief    : Command encodings and FSM state type for the T-FF sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tff_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tff_reg.sv
// ============================================================================
// Module   : tff_reg
// Brief    : Bank of WIDTH synchronous T flip-flops; bit i toggles when t[i]=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/tff_seq_ctrl.sv
// ============================================================================
// Module   : tff_seq_ctrl
// Brief    : Command-driven sequencer producing per-step toggle vectors for a
//            T flip-flop bank (count up/down, load, no-op).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_seq_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           r_state;
    logic [1:0]       r_op;
    logic [LEN_W-1:0] r_rem;
    logic [WIDTH-1:0] r_data;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic             w_accept;
    logic             w_wrap_nxt;

    tff_reg #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .t     (w_t),
        .q     (w_q)
    );

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        w_up    = '0;
        w_dn    = '0;
        w_up[0] = 1'b1;
        w_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up[i] = w_up[i-1] & w_q[i-1];
            w_dn[i] = w_dn[i-1] & ~w_q[i-1];
        end
    end

    always_comb begin
        w_t = '0;
        if (r_state == RUN) begin
            case (r_op)
                OP_UP:   w_t = w_up;
                OP_DOWN: w_t = w_dn;
                OP_LOAD: w_t = w_q ^ r_data;
                default: w_t = '0;
            endcase
        end
    end

    assign w_wrap_nxt = (r_state == RUN) &&
                        (((r_op == OP_UP)   && (&w_q)) ||
                         ((r_op == OP_DOWN) && (~|w_q)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_rem   <= '0;
            r_data  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        case (cmd_op)
                            OP_UP, OP_DOWN: begin
                                r_rem   <= cmd_len;
                                r_state <= (cmd_len != '0) ? RUN : DONE;
                            end
                            OP_LOAD: begin
                                r_rem   <= LEN_W'(1);
                                r_state <= RUN;
                            end
                            default: begin
                                r_rem   <= '0;
                                r_state <= DONE;
                            end
                        endcase
                    end
                end
                RUN: begin
                    r_rem <= r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign q    = w_q;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign wrap = r_wrap;

endmodule

`default_nettype wire
